alu_sequencer: RTL

//  Initiator side of the ALU operand/result interface. Accepts ALU requests over valid/ready,

---
 rtl/alu_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Initiator side of the ALU operand/result interface: registered ALU drive, optional chained passes.
// Optional abort input enabled by defining ALU_SEQ_ABORT_EN.
module alu_sequencer #(
  parameter int unsigned ITER_W = 4,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef ALU_SEQ_ABORT_EN
  input  logic              abort,
`endif
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic              req_form,
  input  logic [1:0]        req_vec,
  input  logic [3:0]        req_lsel,
  input  logic              req_shift_add,
  input  logic [31:0]       req_a,
  input  logic [31:0]       req_b,
  input  logic [31:0]       req_c,
  input  logic [31:0]       req_d,
  input  logic [ITER_W-1:0] req_iter,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [2:0]        alu_op,
  output logic              alu_form,
  output logic [1:0]        alu_vec,
  output logic [3:0]        alu_lsel,
  output logic              alu_shift_add,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [31:0]       alu_c,
  output logic [31:0]       alu_d,
  input  logic [31:0]       alu_y1,
  input  logic [31:0]       alu_y2,
  input  logic [7:0]        alu_cmp,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_y1,
  output logic [31:0]       res_y2,
  output logic [7:0]        res_cmp,
  output logic [TAG_W-1:0]  res_tag
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic              rdy_en_q;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [2:0]        op_q, op_d;
  logic              form_q, form_d;
  logic [1:0]        vec_q, vec_d;
  logic [3:0]        lsel_q, lsel_d;
  logic              sadd_q, sadd_d;
  logic [31:0]       a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic              res_valid_q, res_valid_d;
  logic [31:0]       res_y1_q, res_y1_d, res_y2_q, res_y2_d;
  logic [7:0]        res_cmp_q, res_cmp_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;
  logic              abort_w;
  logic              accept;

`ifdef ALU_SEQ_ABORT_EN
  assign abort_w = abort & (state_q != StIdle);
`else
  assign abort_w = 1'b0;
`endif

  // rdy_en_q keeps req_ready low until the first edge after reset release.
  assign req_ready = rdy_en_q &
                     ((state_q == StIdle) | ((state_q == StDone) & res_ready & ~abort_w));
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tag_d       = tag_q;
    op_d        = op_q;
    form_d      = form_q;
    vec_d       = vec_q;
    lsel_d      = lsel_q;
    sadd_d      = sadd_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    d_d         = d_q;
    res_valid_d = res_valid_q;
    res_y1_d    = res_y1_q;
    res_y2_d    = res_y2_q;
    res_cmp_d   = res_cmp_q;
    res_tag_d   = res_tag_q;

    unique case (state_q)
      StIdle: ;
      StRun: begin
        if (abort_w) begin
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          a_d   = alu_y1;
          b_d   = alu_y2;
          cnt_d = cnt_q - 1'b1;
        end else begin
          res_y1_d    = alu_y1;
          res_y2_d    = alu_y2;
          res_cmp_d   = alu_cmp;
          res_tag_d   = tag_q;
          res_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (abort_w || res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A load overrides the above; accept is only possible from IDLE or a retiring DONE.
    if (accept) begin
      op_d        = req_op;
      form_d      = req_form;
      vec_d       = req_vec;
      lsel_d      = req_lsel;
      sadd_d      = req_shift_add;
      a_d         = req_a;
      b_d         = req_b;
      c_d         = req_c;
      d_d         = req_d;
      cnt_d       = req_iter;
      tag_d       = req_tag;
      res_valid_d = 1'b0;
      state_d     = StRun;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rdy_en_q    <= 1'b0;
      cnt_q       <= '0;
      tag_q       <= '0;
      op_q        <= '0;
      form_q      <= 1'b0;
      vec_q       <= '0;
      lsel_q      <= '0;
      sadd_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      res_valid_q <= 1'b0;
      res_y1_q    <= '0;
      res_y2_q    <= '0;
      res_cmp_q   <= '0;
      res_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= 1'b1;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      op_q        <= op_d;
      form_q      <= form_d;
      vec_q       <= vec_d;
      lsel_q      <= lsel_d;
      sadd_q      <= sadd_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      res_valid_q <= res_valid_d;
      res_y1_q    <= res_y1_d;
      res_y2_q    <= res_y2_d;
      res_cmp_q   <= res_cmp_d;
      res_tag_q   <= res_tag_d;
    end
  end

  assign alu_op        = op_q;
  assign alu_form      = form_q;
  assign alu_vec       = vec_q;
  assign alu_lsel      = lsel_q;
  assign alu_shift_add = sadd_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_c         = c_q;
  assign alu_d         = d_q;
  assign res_valid     = res_valid_q;
  assign res_y1        = res_y1_q;
  assign res_y2        = res_y2_q;
  assign res_cmp       = res_cmp_q;
  assign res_tag       = res_tag_q;

endmodule
